// File: rtl/i2s_receiver.sv
// Slave-mode I2S capture: oversamples sclk/lrck/sdout on sys_clk, deserialises MSB-first
// half-frames and presents one PCM sample per channel through a valid/ready handshake.
module i2s_receiver #(
   parameter int BIT_DEPTH   = 24,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = $clog2(BIT_DEPTH) + 1
) (
   input  logic                 sys_clk,
   input  logic                 sys_reset_n,
   input  logic                 sclk,
   input  logic                 lrck,
   input  logic                 sdout,
   output logic [BIT_DEPTH-1:0] pcm_data_left,
   output logic [BIT_DEPTH-1:0] pcm_data_right,
   output logic [1:0]           pcm_data_valid,
   input  logic [1:0]           pcm_data_ready,
   output logic [1:0]           overrun,
   input  logic                 overrun_clear
);

   localparam int POS_W = $clog2(BIT_DEPTH);

   typedef enum logic [0:0] {
      ST_SYNC  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   logic [SYNC_STAGES-1:0] r_sclk_sync;
   logic [SYNC_STAGES-1:0] r_lrck_sync;
   logic [SYNC_STAGES-1:0] r_sdout_sync;
   logic                   r_sclk_q;

   state_t                 r_state;
   logic                   r_lrck_prev;
   logic [CNT_WIDTH-1:0]   r_idx;
   logic [BIT_DEPTH-1:0]   r_shreg;

   logic [BIT_DEPTH-1:0]   r_data_l;
   logic [BIT_DEPTH-1:0]   r_data_r;
   logic [1:0]             r_valid;
   logic [1:0]             r_overrun;

   logic                   w_sclk_s;
   logic                   w_lrck_s;
   logic                   w_sdout_s;
   logic                   w_rise;
   logic                   w_lr_change;
   logic                   w_idx_ok;
   logic [POS_W-1:0]       w_bit_pos;
   logic                   w_commit;
   logic [1:0]             w_commit_v;
   logic [1:0]             w_take;
   logic [1:0]             w_ovr_set;

   // Pin synchronisers plus the delayed sclk used for rise detection
   always_ff @(posedge sys_clk) begin
      if (!sys_reset_n) begin
         r_sclk_sync  <= '0;
         r_lrck_sync  <= '0;
         r_sdout_sync <= '0;
         r_sclk_q     <= 1'b0;
      end else begin
         r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_lrck_sync  <= {r_lrck_sync[SYNC_STAGES-2:0], lrck};
         r_sdout_sync <= {r_sdout_sync[SYNC_STAGES-2:0], sdout};
         r_sclk_q     <= w_sclk_s;
      end
   end

   assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
   assign w_lrck_s    = r_lrck_sync[SYNC_STAGES-1];
   assign w_sdout_s   = r_sdout_sync[SYNC_STAGES-1];
   assign w_rise      = w_sclk_s & ~r_sclk_q;
   assign w_lr_change = w_rise & (w_lrck_s != r_lrck_prev);
   assign w_idx_ok    = (r_idx < CNT_WIDTH'(BIT_DEPTH));
   assign w_bit_pos   = POS_W'(BIT_DEPTH - 1) - r_idx[POS_W-1:0];

   // A word closes on the rise that sees lrck flip; it belongs to the channel lrck was on
   assign w_commit    = (r_state == ST_SHIFT) & w_lr_change;
   assign w_commit_v  = {w_commit & ~r_lrck_prev, w_commit & r_lrck_prev};
   assign w_take      = r_valid & pcm_data_ready;
   assign w_ovr_set   = w_commit_v & r_valid & ~pcm_data_ready;

   // Frame-alignment FSM and MSB-first deserialiser
   always_ff @(posedge sys_clk) begin
      if (!sys_reset_n) begin
         r_state     <= ST_SYNC;
         r_lrck_prev <= 1'b0;
         r_idx       <= '0;
         r_shreg     <= '0;
      end else begin
         if (w_rise) begin
            r_lrck_prev <= w_lrck_s;
         end
         case (r_state)
            ST_SYNC: begin
               if (w_lr_change) begin
                  r_state <= ST_SHIFT;
                  r_idx   <= '0;
                  r_shreg <= '0;
               end
            end
            ST_SHIFT: begin
               // The bit on the lrck-change rise is the old word's tail and is discarded
               if (w_lr_change) begin
                  r_idx   <= '0;
                  r_shreg <= '0;
               end else if (w_rise && w_idx_ok) begin
                  r_shreg[w_bit_pos] <= w_sdout_s;
                  r_idx              <= r_idx + CNT_WIDTH'(1);
               end
            end
            default: begin
               r_state <= ST_SYNC;
               r_idx   <= '0;
               r_shreg <= '0;
            end
         endcase
      end
   end

   // Per-channel output holding registers, handshake and sticky overrun
   always_ff @(posedge sys_clk) begin
      if (!sys_reset_n) begin
         r_data_l  <= '0;
         r_data_r  <= '0;
         r_valid   <= 2'b00;
         r_overrun <= 2'b00;
      end else begin
         for (int ch = 0; ch < 2; ch++) begin
            if (w_commit_v[ch]) begin
               r_valid[ch] <= 1'b1;
            end else if (w_take[ch]) begin
               r_valid[ch] <= 1'b0;
            end
         end
         if (w_commit_v[1]) begin
            r_data_l <= r_shreg;
         end
         if (w_commit_v[0]) begin
            r_data_r <= r_shreg;
         end
         // A fresh overrun beats a simultaneous clear
         r_overrun <= w_ovr_set | (overrun_clear ? 2'b00 : r_overrun);
      end
   end

   assign pcm_data_left  = r_data_l;
   assign pcm_data_right = r_data_r;
   assign pcm_data_valid = r_valid;
   assign overrun        = r_overrun;

endmodule
